ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_sync_edge.sv | 38 +++
 rtl/ps2_host_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// ps2_pkg -- definitions shared by the PS/2 host transmitter and the PS/2 receiver.
//   ps2_tx_state_t        : host-to-device transmit FSM state encoding
//   PS2_FRAME_BITS        : start + 8 data + parity + stop, counted by the device clock
//   PS2_INHIBIT_CYCLES_DEF: default clock-inhibit time (100 us at 100 MHz)
//   PS2_TIMEOUT_CYCLES_DEF: default frame watchdog limit (20 ms at 100 MHz)
//   PS2_LINE_CLK/DATA     : index of each line in the synchroniser vectors
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_START   = 3'd2,
        ST_BITS    = 3'd3,
        ST_STOP    = 3'd4,
        ST_ACK     = 3'd5,
        ST_RELEASE = 3'd6
    } ps2_tx_state_t;

    localparam int PS2_FRAME_BITS         = 11;
    localparam int PS2_INHIBIT_CYCLES_DEF = 10000;
    localparam int PS2_TIMEOUT_CYCLES_DEF = 2000000;

    localparam int PS2_LINE_CLK  = 0;
    localparam int PS2_LINE_DATA = 1;

    // PS/2 uses odd parity: the parity bit makes the total number of ones odd.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
`timescale 1ns/1ps
// ps2_host_tx_if -- command/status interface of the PS/2 host transmitter.
//   tx_data     : command byte to send
//   tx_valid    : request; accepted when tx_valid && tx_ready
//   tx_ready    : transmitter idle and able to accept a byte
//   done        : one-cycle pulse, frame sent and acknowledged
//   ack_err     : one-cycle pulse, device did not acknowledge
//   timeout_err : one-cycle pulse, frame watchdog expired (0 when watchdog not built)
// Modports: master = command source, slave = transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_sync_edge.sv
`timescale 1ns/1ps
// ps2_sync_edge -- two-flop synchroniser plus falling-edge detector for one
// open-collector PS/2 line.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   line_i    : raw (asynchronous) line level
//   line_sync : synchronised line level
//   line_fall : 1 when the synchronised level was 1 last cycle and is 0 now
// Flops reset to 1 (the released/pulled-up level) so that leaving reset never
// produces a spurious falling edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_sync,
    output logic line_fall
);

    logic meta_reg;
    logic sync_reg;
    logic sync_d_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg   <= 1'b1;
            sync_reg   <= 1'b1;
            sync_d_reg <= 1'b1;
        end else begin
            meta_reg   <= line_i;
            sync_reg   <= meta_reg;
            sync_d_reg <= sync_reg;
        end
    end

    assign line_sync = sync_reg;
    assign line_fall = sync_d_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Inhibits the bus by holding the PS/2 clock low, issues the start bit, then
// shifts out 8 data bits (LSB first), odd parity and the stop bit on the
// device-generated falling clock edges, and checks the device acknowledge.
//   Parameters : INHIBIT_CYCLES (clock-low time before start),
//                TIMEOUT_CYCLES (watchdog limit from START entry)
//   clk, rst   : system clock, asynchronous active-low reset
//   bus        : ps2_host_tx_if.slave (tx_data/tx_valid/tx_ready, done,
//                ack_err, timeout_err)
//   ps2_clk_i, ps2_data_i   : raw line levels
//   ps2_clk_oe, ps2_data_oe : 1 = pull line low, 0 = release
// Build option: define PS2_TX_TIMEOUT_EN to include the frame watchdog;
// otherwise timeout_err is constant 0 and the FSM waits indefinitely.
// INHIBIT_CYCLES must exceed the synchroniser latency (3 cycles) so the
// falling edge caused by our own clock inhibit is seen before START.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    // ---------------- line synchronisers ----------------
    logic [1:0] line_raw;
    logic [1:0] line_sync;
    logic [1:0] line_fall;

    assign line_raw[PS2_LINE_CLK]  = ps2_clk_i;
    assign line_raw[PS2_LINE_DATA] = ps2_data_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        ps2_sync_edge u_sync (
            .clk       (clk),
            .rst       (rst),
            .line_i    (line_raw[gi]),
            .line_sync (line_sync[gi]),
            .line_fall (line_fall[gi])
        );
    end

    logic clk_sync;
    logic data_sync;
    logic clk_fall;
    logic unused_data_fall;

    assign clk_sync  = line_sync[PS2_LINE_CLK];
    assign data_sync = line_sync[PS2_LINE_DATA];
    assign clk_fall  = line_fall[PS2_LINE_CLK];
    // The transmitter only reacts to device clock edges, never data edges.
    assign unused_data_fall = line_fall[PS2_LINE_DATA];

    // ---------------- FSM state ----------------
    ps2_tx_state_t    state_reg;
    logic             tx_ready_reg;
    logic             clk_oe_reg;
    logic             data_oe_reg;
    logic             done_reg;
    logic             ack_err_reg;
    logic [8:0]       shift_reg;     // {parity, data[7:0]}, bit 0 goes out next
    logic [3:0]       bit_cnt_reg;   // device falling edges seen in this frame
    logic [INH_W-1:0] inh_cnt_reg;

    logic done_evt;
    logic ack_fail_evt;

    assign done_evt     = (state_reg == ST_RELEASE) && clk_sync && data_sync;
    assign ack_fail_evt = (state_reg == ST_ACK) && clk_fall && data_sync;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_err_reg;
    logic            in_frame;
    logic            wd_fire;

    assign in_frame = (state_reg == ST_START) || (state_reg == ST_BITS) ||
                      (state_reg == ST_STOP)  || (state_reg == ST_ACK)  ||
                      (state_reg == ST_RELEASE);
    // A frame that finishes on the expiry cycle is reported as finished.
    assign wd_fire  = in_frame && (wd_cnt_reg == WD_LAST) && !done_evt && !ack_fail_evt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            tx_ready_reg <= 1'b0;
            clk_oe_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
            done_reg     <= 1'b0;
            ack_err_reg  <= 1'b0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            inh_cnt_reg  <= '0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            done_reg    <= 1'b0;
            ack_err_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    clk_oe_reg   <= 1'b0;
                    data_oe_reg  <= 1'b0;
                    tx_ready_reg <= 1'b1;
                    if (bus.tx_valid && tx_ready_reg) begin
                        tx_ready_reg <= 1'b0;
                        shift_reg    <= {ps2_odd_parity(bus.tx_data), bus.tx_data};
                        bit_cnt_reg  <= '0;
                        inh_cnt_reg  <= '0;
                        clk_oe_reg   <= 1'b1;
                        data_oe_reg  <= (INHIBIT_CYCLES == 1);
                        state_reg    <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (inh_cnt_reg == INH_LAST) begin
                        // Release the clock with data already low: start bit.
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b1;
                        state_reg   <= ST_START;
                    end else begin
                        inh_cnt_reg <= inh_cnt_reg + 1'b1;
                        // Pull data during the final inhibit cycle.
                        data_oe_reg <= (INH_W'(inh_cnt_reg + 1'b1) == INH_LAST);
                    end
                end

                ST_START: begin
                    if (clk_fall) begin
                        data_oe_reg <= ~shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[8:1]};
                        bit_cnt_reg <= 4'd1;
                        state_reg   <= ST_BITS;
                    end
                end

                ST_BITS: begin
                    if (clk_fall) begin
                        data_oe_reg <= ~shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[8:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        // Edge 9 puts the parity bit out.
                        if (bit_cnt_reg == 4'd8) begin
                            state_reg <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    if (clk_fall) begin
                        data_oe_reg <= 1'b0;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        state_reg   <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    if (clk_fall) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (ack_fail_evt) begin
                            ack_err_reg  <= 1'b1;
                            tx_ready_reg <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end else begin
                            state_reg <= ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (done_evt) begin
                        done_reg     <= 1'b1;
                        tx_ready_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end

                default: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            timeout_err_reg <= 1'b0;
            if (state_reg == ST_INHIBIT) begin
                wd_cnt_reg <= '0;
            end else if (wd_fire) begin
                // Overrides whatever the state logic decided this cycle.
                timeout_err_reg <= 1'b1;
                clk_oe_reg      <= 1'b0;
                data_oe_reg     <= 1'b0;
                tx_ready_reg    <= 1'b1;
                state_reg       <= ST_IDLE;
            end else if (in_frame) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
`endif
        end
    end

    assign ps2_clk_oe   = clk_oe_reg;
    assign ps2_data_oe  = data_oe_reg;
    assign bus.tx_ready = tx_ready_reg;
    assign bus.done     = done_reg;
    assign bus.ack_err  = ack_err_reg;
`ifdef PS2_TX_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_reg;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a PS/2 device model.
// Expected line bits are queued when a byte is sent and popped as the device
// model samples the data line after each clock pulse.
module tb_ps2_host_tx;

    localparam int INH = 10;
    localparam int TMO = 500;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk_pull  = 1'b0;
    logic dev_data_pull = 1'b0;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    wire  ps2_clk_line;
    wire  ps2_data_line;

    // Open-collector wired-AND of host and device pull-downs.
    assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_pull);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_pull);

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ps2_clk_i   (ps2_clk_line),
        .ps2_data_i  (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int done_cnt  = 0;
    int ack_cnt   = 0;
    int to_cnt    = 0;
    int hs_cnt    = 0;
    logic exp_q[$];

    // Event counters for pulses and accepted handshakes.
    always @(posedge clk) begin
        if (bus.done === 1'b1)        done_cnt++;
        if (bus.ack_err === 1'b1)     ack_cnt++;
        if (bus.timeout_err === 1'b1) to_cnt++;
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand a byte to the DUT, queue its expected line bits and check the inhibit phase.
    task automatic send_byte(input logic [7:0] b, input bit hold_valid);
        int n = 0;
        int cnt = 0;
        int cnt_d = 0;
        while (bus.tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", bus.tx_ready, 1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        if (hold_valid) bus.tx_data = 8'h3C;
        else            bus.tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
        while (ps2_clk_oe === 1'b1 && cnt < 1000) begin
            cnt++;
            if (ps2_data_oe === 1'b1) cnt_d++;
            @(negedge clk);
        end
        check("inhibit_len", cnt, INH);
        check("inhibit_data_cycles", cnt_d, 1);
        check("start_bit_oe", ps2_data_oe, 1);
    endtask

    // Device clocks 11 edges; samples data while clock is low before release.
    // Returns early after edge abort_at with reset asserted.
    task automatic device_clock(input bit ack_ok, input int abort_at);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack_ok) dev_data_pull = 1'b1;
            repeat (6) @(negedge clk);
            dev_clk_pull = 1'b1;
            repeat (8) @(negedge clk);
            if (k <= 10) begin
                check($sformatf("line_bit%0d", k), ps2_data_line,
                      (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx);
            end
            if (k == abort_at) begin
                rst = 1'b0;
                #1;
                check("abort_clk_oe", ps2_clk_oe, 0);
                check("abort_data_oe", ps2_data_oe, 0);
                check("abort_ready", bus.tx_ready, 0);
                dev_clk_pull  = 1'b0;
                dev_data_pull = 1'b0;
                bus.tx_valid  = 1'b0;
                exp_q.delete();
                return;
            end
            if (k == 11) bus.tx_valid = 1'b0;
            dev_clk_pull = 1'b0;
            if (k == 11) begin
                repeat (2) @(negedge clk);
                dev_data_pull = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack_ok, input bit hold_valid,
                             input int abort_at);
        int d0 = done_cnt;
        int a0 = ack_cnt;
        int h0 = hs_cnt;
        int n = 0;
        send_byte(b, hold_valid);
        device_clock(ack_ok, abort_at);
        if (abort_at > 0) begin
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("ready_after_abort", bus.tx_ready, 1);
            repeat (5) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_no_ack_err", ack_cnt - a0, 0);
            $display("frame %02h: aborted by reset", b);
        end else begin
            while (bus.tx_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("ready_return", bus.tx_ready, 1);
            check("oe_idle", {ps2_clk_oe, ps2_data_oe}, 0);
            repeat (20) @(negedge clk);
            check("done_pulses", done_cnt - d0, ack_ok ? 1 : 0);
            check("ack_err_pulses", ack_cnt - a0, ack_ok ? 0 : 1);
            check("handshakes", hs_cnt - h0, 1);
            check("clk_oe_after", ps2_clk_oe, 0);
            check("scoreboard_empty", exp_q.size(), 0);
            $display("frame %02h: ack_ok=%0d done=%0d ack_err=%0d", b, ack_ok,
                     done_cnt - d0, ack_cnt - a0);
        end
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", bus.tx_ready, 0);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_done", bus.done, 0);
        check("reset_ack_err", bus.ack_err, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_first_edge", bus.tx_ready, 1);

        run_frame(8'hED, 1'b1, 1'b0, 0);
        run_frame(8'hF4, 1'b1, 1'b0, 0);
        run_frame(8'h81, 1'b0, 1'b0, 0);
        run_frame(8'hED, 1'b1, 1'b0, 4);
        run_frame(8'h55, 1'b1, 1'b0, 0);
        run_frame(8'hA5, 1'b1, 1'b1, 0);

`ifdef PS2_TX_TIMEOUT_EN
        begin
            int t0 = to_cnt;
            int n = 0;
            send_byte(8'h96, 1'b0);
            while (bus.timeout_err !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("timeout_latency", n, TMO);
            check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            check("timeout_ready", bus.tx_ready, 1);
            exp_q.delete();
            repeat (3) @(negedge clk);
            check("timeout_pulses", to_cnt - t0, 1);
            $display("frame 96: watchdog expired after %0d cycles", n);
        end
`else
        check("no_timeout_pulses", to_cnt, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
